// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: writeback-stage write,
// multi-cycle result stream, registered register-file write and scoreboard query.
interface wb_port_arbiter_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          P_RW;
  logic [AW-1:0] P_DA;
  logic [DW-1:0] P_D;
  logic          M_VALID;
  logic [AW-1:0] M_DA;
  logic [DW-1:0] M_D;
  logic          M_READY;
  logic          RF_WE;
  logic [AW-1:0] RF_DA;
  logic [DW-1:0] RF_D;
  logic          STALL;
  logic [AW-1:0] Q_DA;
  logic          Q_HIT;
  logic [CW-1:0] Q_COUNT;

  modport slave (
    input  P_RW, P_DA, P_D, M_VALID, M_DA, M_D, Q_DA,
    output M_READY, RF_WE, RF_DA, RF_D, STALL, Q_HIT, Q_COUNT
  );

  modport master (
    output P_RW, P_DA, P_D, M_VALID, M_DA, M_D, Q_DA,
    input  M_READY, RF_WE, RF_DA, RF_D, STALL, Q_HIT, Q_COUNT
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage (priority) and a
// FIFO of multi-cycle results, with a starvation guard that stalls to force a drain.
module wb_port_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            CLOCK,
  input  logic            RESET,
  wb_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WW-1:0] LIMIT_C = WW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [AW-1:0] fifo_da_q [DEPTH];
  logic [AW-1:0] fifo_da_d [DEPTH];
  logic [DW-1:0] fifo_d_q  [DEPTH];
  logic [DW-1:0] fifo_d_d  [DEPTH];
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_da_q, rf_da_d;
  logic [DW-1:0] rf_d_q, rf_d_d;

  logic          m_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          p_req_s;
  logic          fifo_ne_s;
  logic          grant_s;
  logic [AW-1:0] gnt_da_s;
  logic [DW-1:0] gnt_d_s;
  logic          q_hit_s;

  // Handshake qualifiers; ready depends only on the registered count.
  always_comb begin
    m_ready_s = RESET && (count_q < DEPTH_C);
    push_s    = bus.M_VALID && m_ready_s && (bus.M_DA != {AW{1'b0}});
    p_req_s   = bus.P_RW && (bus.P_DA != {AW{1'b0}});
    fifo_ne_s = (count_q != {CW{1'b0}});
  end

  // Grant selection, starvation counter and next state.
  always_comb begin
    pop_s    = 1'b0;
    grant_s  = 1'b0;
    gnt_da_s = bus.P_DA;
    gnt_d_s  = bus.P_D;
    wait_d   = wait_q;
    case (state_q)
      S_FORCE: begin
        pop_s    = 1'b1;
        grant_s  = 1'b1;
        gnt_da_s = fifo_da_q[rd_ptr_q];
        gnt_d_s  = fifo_d_q[rd_ptr_q];
        wait_d   = {WW{1'b0}};
      end
      S_IDLE, S_PEND: begin
        if (p_req_s) begin
          grant_s = 1'b1;
          if (fifo_ne_s) begin
            wait_d = wait_q + WW'(1'b1);
          end else begin
            wait_d = {WW{1'b0}};
          end
        end else if (fifo_ne_s) begin
          pop_s    = 1'b1;
          grant_s  = 1'b1;
          gnt_da_s = fifo_da_q[rd_ptr_q];
          gnt_d_s  = fifo_d_q[rd_ptr_q];
          wait_d   = {WW{1'b0}};
        end else begin
          wait_d = {WW{1'b0}};
        end
      end
      default: begin
        wait_d = {WW{1'b0}};
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase

    // A denial only counts toward starvation while the FIFO holds something.
    if ((state_q != S_FORCE) && p_req_s && fifo_ne_s && (wait_d == LIMIT_C)) begin
      state_d = S_FORCE;
    end else if (count_d != {CW{1'b0}}) begin
      state_d = S_PEND;
    end else begin
      state_d = S_IDLE;
    end
  end

  // FIFO storage, pointers and the registered write-port request.
  always_comb begin
    fifo_da_d = fifo_da_q;
    fifo_d_d  = fifo_d_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_s) begin
      fifo_da_d[wr_ptr_q] = bus.M_DA;
      fifo_d_d[wr_ptr_q]  = bus.M_D;
      wr_ptr_d            = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    rf_we_d = grant_s;
    if (grant_s) begin
      rf_da_d = gnt_da_s;
      rf_d_d  = gnt_d_s;
    end else begin
      rf_da_d = rf_da_q;
      rf_d_d  = rf_d_q;
    end
  end

  // Scoreboard query over the currently valid entries (same-cycle push excluded).
  always_comb begin
    logic [PW-1:0] idx;
    q_hit_s = 1'b0;
    idx     = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (fifo_da_q[idx] == bus.Q_DA)) begin
        q_hit_s = 1'b1;
      end else begin
        q_hit_s = q_hit_s;
      end
    end
    if (bus.Q_DA == {AW{1'b0}}) begin
      q_hit_s = 1'b0;
    end else begin
      q_hit_s = q_hit_s;
    end
  end

  // State and datapath registers; reset flushes queued entries without writing them.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      count_q  <= {CW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wait_q   <= {WW{1'b0}};
      rf_we_q  <= 1'b0;
      rf_da_q  <= {AW{1'b0}};
      rf_d_q   <= {DW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_da_q[i] <= {AW{1'b0}};
        fifo_d_q[i]  <= {DW{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wait_q    <= wait_d;
      rf_we_q   <= rf_we_d;
      rf_da_q   <= rf_da_d;
      rf_d_q    <= rf_d_d;
      fifo_da_q <= fifo_da_d;
      fifo_d_q  <= fifo_d_d;
    end
  end

  assign bus.M_READY = m_ready_s;
  assign bus.RF_WE   = rf_we_q;
  assign bus.RF_DA   = rf_da_q;
  assign bus.RF_D    = rf_d_q;
  assign bus.STALL   = (state_q == S_FORCE);
  assign bus.Q_HIT   = q_hit_s;
  assign bus.Q_COUNT = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a behavioural model predicts every grant,
// expected writes are queued and compared as RF_WE pulses appear.
module tb_wb_port_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int stall_cycles = 0;

  logic [AW+DW-1:0] mq[$];
  logic [AW+DW-1:0] exp_q[$];
  int               m_state = 0;
  int               m_wait  = 0;
  logic             m_g     = 1'b0;
  logic [AW-1:0]    m_rf_da = '0;
  logic [DW-1:0]    m_rf_d  = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic p_rw, input logic [AW-1:0] p_da, input logic [DW-1:0] p_d,
                       input logic m_v, input logic [AW-1:0] m_da, input logic [DW-1:0] m_d,
                       input logic [AW-1:0] q_da);
    bus.P_RW = p_rw; bus.P_DA = p_da; bus.P_D = p_d;
    bus.M_VALID = m_v; bus.M_DA = m_da; bus.M_D = m_d;
    bus.Q_DA = q_da;
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_state = 0; m_wait = 0; m_g = 1'b0;
    m_rf_da = '0; m_rf_d = '0;
  endtask

  // Evaluated with inputs stable before the edge: checks combinational outputs,
  // then advances the model to its post-edge state.
  task automatic model_step();
    int sz = mq.size();
    bit ready = (sz < DEPTH);
    bit hit = 1'b0;
    bit push, forced;
    logic [AW+DW-1:0] e;
    foreach (mq[i]) if (bus.Q_DA != 0 && mq[i][AW+DW-1:DW] == bus.Q_DA) hit = 1'b1;
    check_eq("m_ready", bus.M_READY, ready);
    check_eq("q_count", bus.Q_COUNT, sz);
    check_eq("q_hit", bus.Q_HIT, hit);
    check_eq("stall", bus.STALL, m_state == 2);
    if (bus.STALL) stall_cycles++;
    push = bus.M_VALID && ready && (bus.M_DA != 0);
    forced = 1'b0;
    m_g = 1'b0;
    e = '0;
    if (m_state == 2) begin
      e = mq.pop_front(); m_g = 1'b1; m_wait = 0;
    end else if (bus.P_RW && bus.P_DA != 0) begin
      e = {bus.P_DA, bus.P_D}; m_g = 1'b1;
      if (sz > 0) begin
        m_wait++;
        if (m_wait == LIMIT) forced = 1'b1;
      end else m_wait = 0;
    end else if (sz > 0) begin
      e = mq.pop_front(); m_g = 1'b1; m_wait = 0;
    end else m_wait = 0;
    if (push) mq.push_back({bus.M_DA, bus.M_D});
    if (m_g) begin
      exp_q.push_back(e);
      m_rf_da = e[AW+DW-1:DW];
      m_rf_d  = e[DW-1:0];
    end
    m_state = forced ? 2 : (mq.size() > 0 ? 1 : 0);
  endtask

  task automatic tick();
    logic [AW+DW-1:0] e;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    check_eq("rf_we", bus.RF_WE, m_g);
    if (bus.RF_WE) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("rf_da", bus.RF_DA, e[AW+DW-1:DW]);
        check_eq("rf_d", bus.RF_D, e[DW-1:0]);
      end
    end else if (m_g && exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    check_eq("rf_da_hold", bus.RF_DA, m_rf_da);
    check_eq("rf_d_hold", bus.RF_D, m_rf_d);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_0005, '0);
    // Reset: ready held low even with a valid request.
    repeat (3) @(negedge clk);
    check_eq("rst_m_ready", bus.M_READY, 1'b0);
    check_eq("rst_rf_we", bus.RF_WE, 1'b0);
    check_eq("rst_rf_da", bus.RF_DA, 0);
    check_eq("rst_rf_d", bus.RF_D, 0);
    check_eq("rst_stall", bus.STALL, 1'b0);
    check_eq("rst_q_count", bus.Q_COUNT, 0);
    bus.M_VALID = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("rel_m_ready", bus.M_READY, 1'b1);
    @(posedge clk); #1;

    // Pipeline-only traffic.
    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b0, '0, '0, '0);
    tick();
    check_eq("t2_rf_da", bus.RF_DA, 5'd3);
    check_eq("t2_rf_d", bus.RF_D, 32'hFFFF_FFFF);
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, '0, '0, '0);
    tick();
    check_eq("t2_r0_we", bus.RF_WE, 1'b0);

    // Idle drain of a single queued result.
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hDDDD_DDDD, 5'd7);
    tick();
    check_eq("t3_count", bus.Q_COUNT, 1);
    check_eq("t3_hit", bus.Q_HIT, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd7);
    tick();
    tick();
    check_eq("t3_rf_da", bus.RF_DA, 5'd7);
    check_eq("t3_rf_d", bus.RF_D, 32'hDDDD_DDDD);
    check_eq("t3_count0", bus.Q_COUNT, 0);

    // Starvation guard: one queued entry against a continuous pipeline writer.
    stall_cycles = 0;
    drive(1'b1, 5'd4, 32'hA4A4_A4A4, 1'b1, 5'd9, 32'h9999_9999, 5'd9);
    tick();
    bus.M_VALID = 1'b0;
    repeat (8) tick();
    check_eq("t4_stall_once", stall_cycles, 1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    repeat (2) tick();

    // Full FIFO: four pushes under pipeline pressure, a fifth is refused.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd9, 32'h9000_0000 + i, 1'b1, 5'(10 + i), 32'h5000_0000 + i, 5'd12);
      tick();
    end
    check_eq("t5_full_ready", bus.M_READY, 1'b0);
    check_eq("t5_full_count", bus.Q_COUNT, 4);
    drive(1'b1, 5'd9, 32'h9000_0003, 1'b1, 5'd14, 32'h5000_0004, 5'd14);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd14);
    repeat (8) tick();
    check_eq("t5_empty", bus.Q_COUNT, 0);

    // Reset while draining in the forced state with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'(20 + i), 32'hC000_0000 + i, '0);
      tick();
    end
    bus.M_VALID = 1'b0;
    n = 0;
    while (!(m_state == 2 && mq.size() == 3) && n < 10) begin
      tick();
      n++;
    end
    check_eq("t6_force", bus.STALL, 1'b1);
    check_eq("t6_count3", bus.Q_COUNT, 3);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rf_we", bus.RF_WE, 1'b0);
    check_eq("t6_stall", bus.STALL, 1'b0);
    check_eq("t6_count", bus.Q_COUNT, 0);
    check_eq("t6_ready", bus.M_READY, 1'b0);
    model_clear();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    #1;
    rst_n = 1'b1;
    repeat (6) tick();

    // Randomised traffic; writeback inputs frozen while the model is stalling.
    for (int c = 0; c < 300; c++) begin
      if (m_state != 2) begin
        bus.P_RW = 1'($urandom_range(0, 1));
        bus.P_DA = 5'($urandom_range(0, 7));
        bus.P_D  = $urandom;
      end
      bus.M_VALID = 1'($urandom_range(0, 2) != 0);
      bus.M_DA    = 5'($urandom_range(0, 7));
      bus.M_D     = $urandom;
      bus.Q_DA    = 5'($urandom_range(0, 7));
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    repeat (10) tick();
    check_eq("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
